// File: rtl/gps_fe_pkg.sv
// Shared constants for the GPS front-end conditioning path: PRBS7 generator
// parameters, decimator width and default monitor width.
package gps_fe_pkg;

  localparam int DEFAULT_WIN_W = 24;
  localparam int DCNT_W        = 4;
  localparam int PRBS_W        = 7;
  localparam int PRBS_TAP_HI   = 6;
  localparam int PRBS_TAP_LO   = 5;

  localparam logic [PRBS_W-1:0] PRBS_SEED = 7'h7F;
  localparam logic [DCNT_W-1:0] DCNT_ONE  = 4'd1;

  // x^7 + x^6 + 1, shifting toward the MSB
  function automatic logic [PRBS_W-1:0] prbs7_next(input logic [PRBS_W-1:0] s);
    return {s[PRBS_W-2:0], s[PRBS_TAP_HI] ^ s[PRBS_TAP_LO]};
  endfunction

endpackage

// File: rtl/fe_mag_monitor.sv
// Windowed count of if_mag=1 samples, published once per completed window
// for firmware AGC / level monitoring.
module fe_mag_monitor
  import gps_fe_pkg::*;
#(
  parameter int WIN_W = DEFAULT_WIN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  input  logic             if_mag,
  input  logic [WIN_W-1:0] cfg_win,
  output logic [WIN_W-1:0] mag_count,
  output logic             mag_ready
);

  localparam logic [WIN_W-1:0] WIN_ONE = {{(WIN_W-1){1'b0}}, 1'b1};

  logic [WIN_W-1:0] scnt_q, scnt_d;
  logic [WIN_W-1:0] acc_q, acc_d;
  logic [WIN_W-1:0] mag_count_q, mag_count_d;
  logic             mag_ready_q, mag_ready_d;
  logic [WIN_W-1:0] acc_inc_s;

  // window bookkeeping; a shrunk cfg_win closes the window on the next sample
  always_comb begin
    scnt_d      = scnt_q;
    acc_d       = acc_q;
    mag_count_d = mag_count_q;
    mag_ready_d = 1'b0;
    acc_inc_s   = acc_q + {{(WIN_W-1){1'b0}}, if_mag};
    if (cfg_win == {WIN_W{1'b0}}) begin
      scnt_d = {WIN_W{1'b0}};
      acc_d  = {WIN_W{1'b0}};
    end else if (if_valid) begin
      if (scnt_q >= (cfg_win - WIN_ONE)) begin
        mag_count_d = acc_inc_s;
        mag_ready_d = 1'b1;
        scnt_d      = {WIN_W{1'b0}};
        acc_d       = {WIN_W{1'b0}};
      end else begin
        scnt_d = scnt_q + WIN_ONE;
        acc_d  = acc_inc_s;
      end
    end else begin
      scnt_d = scnt_q;
    end
  end

  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      scnt_q      <= {WIN_W{1'b0}};
      acc_q       <= {WIN_W{1'b0}};
      mag_count_q <= {WIN_W{1'b0}};
      mag_ready_q <= 1'b0;
    end else begin
      scnt_q      <= scnt_d;
      acc_q       <= acc_d;
      mag_count_q <= mag_count_d;
      mag_ready_q <= mag_ready_d;
    end
  end

  assign mag_count = mag_count_q;
  assign mag_ready = mag_ready_q;

endmodule

// File: rtl/fe_sample_conditioner.sv
// Front-end conditioning stage ahead of the baseband tracking channels:
// synchroniser, decimator, PRBS7 test source, output register and level monitor.
module fe_sample_conditioner
  import gps_fe_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int WIN_W       = DEFAULT_WIN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fe_sign,
  input  logic              fe_mag,
  input  logic [DCNT_W-1:0] cfg_decim,
  input  logic              cfg_sign_inv,
  input  logic              cfg_test_en,
  input  logic [WIN_W-1:0]  cfg_win,
  output logic              if_sign,
  output logic              if_mag,
  output logic              if_valid,
  output logic [WIN_W-1:0]  mag_count,
  output logic              mag_ready
);

  logic [SYNC_STAGES-1:0] sync_sign_q, sync_sign_d;
  logic [SYNC_STAGES-1:0] sync_mag_q, sync_mag_d;
  logic [DCNT_W-1:0]      dcnt_q, dcnt_d;
  logic [PRBS_W-1:0]      lfsr_q, lfsr_d;
  logic                   if_sign_q, if_sign_d;
  logic                   if_mag_q, if_mag_d;
  logic                   if_valid_q, if_valid_d;
  logic                   strobe_s, sel_sign_s, sel_mag_s;

  // next state of the sample path; the LFSR runs on strobes even in live mode
  always_comb begin
    sync_sign_d = {sync_sign_q[SYNC_STAGES-2:0], fe_sign};
    sync_mag_d  = {sync_mag_q[SYNC_STAGES-2:0], fe_mag};
    strobe_s    = (dcnt_q >= cfg_decim);
    if (cfg_test_en) begin
      sel_sign_s = lfsr_q[PRBS_TAP_HI];
      sel_mag_s  = lfsr_q[PRBS_TAP_LO];
    end else begin
      sel_sign_s = sync_sign_q[SYNC_STAGES-1];
      sel_mag_s  = sync_mag_q[SYNC_STAGES-1];
    end
    if_valid_d = strobe_s;
    if (strobe_s) begin
      dcnt_d    = {DCNT_W{1'b0}};
      lfsr_d    = prbs7_next(lfsr_q);
      if_sign_d = sel_sign_s ^ cfg_sign_inv;
      if_mag_d  = sel_mag_s;
    end else begin
      dcnt_d    = dcnt_q + DCNT_ONE;
      lfsr_d    = lfsr_q;
      if_sign_d = if_sign_q;
      if_mag_d  = if_mag_q;
    end
  end

  // state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_sign_q <= {SYNC_STAGES{1'b0}};
      sync_mag_q  <= {SYNC_STAGES{1'b0}};
      dcnt_q      <= {DCNT_W{1'b0}};
      lfsr_q      <= PRBS_SEED;
      if_sign_q   <= 1'b0;
      if_mag_q    <= 1'b0;
      if_valid_q  <= 1'b0;
    end else begin
      sync_sign_q <= sync_sign_d;
      sync_mag_q  <= sync_mag_d;
      dcnt_q      <= dcnt_d;
      lfsr_q      <= lfsr_d;
      if_sign_q   <= if_sign_d;
      if_mag_q    <= if_mag_d;
      if_valid_q  <= if_valid_d;
    end
  end

  assign if_sign  = if_sign_q;
  assign if_mag   = if_mag_q;
  assign if_valid = if_valid_q;

  fe_mag_monitor #(
    .WIN_W (WIN_W)
  ) u_mag_monitor (
    .clk       (clk),
    .rst       (rst),
    .if_valid  (if_valid_q),
    .if_mag    (if_mag_q),
    .cfg_win   (cfg_win),
    .mag_count (mag_count),
    .mag_ready (mag_ready)
  );

endmodule

// File: tb/tb_fe_sample_conditioner.sv
// Self-checking bench for fe_sample_conditioner: directed vector table, corner
// sequences, and randomized traffic against a behavioural reference model.
module tb_fe_sample_conditioner;

  localparam int SYNC_STAGES = 2;
  localparam int WIN_W       = 24;

  logic             clk = 1'b0;
  logic             rst, fe_sign, fe_mag, cfg_sign_inv, cfg_test_en;
  logic [3:0]       cfg_decim;
  logic [WIN_W-1:0] cfg_win;
  logic             if_sign, if_mag, if_valid, mag_ready;
  logic [WIN_W-1:0] mag_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fe_sample_conditioner #(.SYNC_STAGES(SYNC_STAGES), .WIN_W(WIN_W)) dut (
    .clk(clk), .rst(rst), .fe_sign(fe_sign), .fe_mag(fe_mag),
    .cfg_decim(cfg_decim), .cfg_sign_inv(cfg_sign_inv), .cfg_test_en(cfg_test_en),
    .cfg_win(cfg_win), .if_sign(if_sign), .if_mag(if_mag), .if_valid(if_valid),
    .mag_count(mag_count), .mag_ready(mag_ready)
  );

  // ---------------- reference model ----------------
  bit prbs_seq[127];       // PRBS7 bit stream as seen at lfsr[6], one bit per strobe
  bit m_sync_s[$], m_sync_m[$];
  int m_gap, m_pidx, m_count;
  bit m_sign, m_mag, m_valid, m_ready;
  bit m_win[$];            // if_mag samples of the currently open window

  task automatic model_reset();
    m_sync_s = {}; m_sync_m = {};
    for (int i = 0; i < SYNC_STAGES; i++) begin
      m_sync_s.push_back(1'b0); m_sync_m.push_back(1'b0);
    end
    m_gap = 0; m_pidx = 0; m_count = 0; m_win = {};
    m_sign = 1'b0; m_mag = 1'b0; m_valid = 1'b0; m_ready = 1'b0;
  endtask

  task automatic model_edge();
    bit ss, sm, strobe;
    int ones;
    if (rst) begin
      model_reset();
      return;
    end
    m_ready = 1'b0;
    if (cfg_win == 0) m_win = {};
    else if (m_valid) begin
      m_win.push_back(m_mag);
      if (m_win.size() >= cfg_win) begin
        ones = 0;
        foreach (m_win[i]) ones += int'(m_win[i]);
        m_count = ones; m_ready = 1'b1; m_win = {};
      end
    end
    strobe = (m_gap >= int'(cfg_decim));
    ss = cfg_test_en ? prbs_seq[m_pidx]           : m_sync_s[0];
    sm = cfg_test_en ? prbs_seq[(m_pidx + 1) % 127] : m_sync_m[0];
    m_valid = strobe;
    if (strobe) begin
      m_sign = ss ^ cfg_sign_inv; m_mag = sm; m_gap = 0;
      m_pidx = (m_pidx + 1) % 127;
    end else begin
      m_gap++;
    end
    void'(m_sync_s.pop_front()); m_sync_s.push_back(fe_sign);
    void'(m_sync_m.pop_front()); m_sync_m.push_back(fe_mag);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // one clock: model consumes the inputs the DUT samples, then outputs compared
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("model_if_valid", if_valid, m_valid);
    check("model_if_sign", if_sign, m_sign);
    check("model_if_mag", if_mag, m_mag);
    check("model_mag_ready", mag_ready, m_ready);
    check("model_mag_count", mag_count, m_count);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit rst, fs, fm, test, inv;
    logic [3:0] decim;
    bit es, em, ev;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit fs, bit fm, bit t, bit inv, logic [3:0] d,
                              bit es, bit em, bit ev);
    vec_t v;
    v.rst = r; v.fs = fs; v.fm = fm; v.test = t; v.inv = inv; v.decim = d;
    v.es = es; v.em = em; v.ev = ev;
    return v;
  endfunction

  int found, cnt_at;

  initial begin
    prbs_seq[0] = 1'b1;
    for (int n = 1; n < 7; n++) prbs_seq[n] = 1'b1;
    for (int n = 7; n < 127; n++) prbs_seq[n] = prbs_seq[n-7] ^ prbs_seq[n-6];
    model_reset();

    // pass-through: sign appears on the third clock after reset
    tbl.push_back(mk(1, 1, 0, 0, 0, 4'd0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 4'd0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 4'd0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 4'd0, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 4'd0, 1, 0, 1));
    // PRBS from seed
    tbl.push_back(mk(1, 0, 0, 1, 0, 4'd0, 0, 0, 0));
    for (int k = 0; k < 6; k++) tbl.push_back(mk(0, 0, 0, 1, 0, 4'd0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 4'd0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 4'd0, 0, 0, 1));
    // PRBS with sign inversion
    tbl.push_back(mk(1, 0, 0, 1, 1, 4'd0, 0, 0, 0));
    for (int k = 0; k < 6; k++) tbl.push_back(mk(0, 0, 0, 1, 1, 4'd0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 4'd0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 4'd0, 1, 0, 1));
    // decimate by 3: first strobe on the third clock, then hold
    tbl.push_back(mk(1, 0, 0, 1, 0, 4'd2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 4'd2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 4'd2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 4'd2, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 4'd2, 1, 1, 0));

    cfg_win = '0;
    foreach (tbl[i]) begin
      rst = tbl[i].rst; fe_sign = tbl[i].fs; fe_mag = tbl[i].fm;
      cfg_test_en = tbl[i].test; cfg_sign_inv = tbl[i].inv; cfg_decim = tbl[i].decim;
      step();
      check("tbl_if_sign", if_sign, tbl[i].es);
      check("tbl_if_mag", if_mag, tbl[i].em);
      check("tbl_if_valid", if_valid, tbl[i].ev);
    end

    // decimation corner cases
    cfg_test_en = 1'b0; cfg_sign_inv = 1'b0; fe_mag = 1'b0; fe_sign = 1'b1;
    cfg_decim = 4'd3; rst = 1'b1; step(); rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      check("decim3_valid", if_valid, (k % 4) == 0);
    end
    check("decim3_sign", if_sign, 1);
    fe_sign = 1'b0;
    for (int k = 13; k <= 15; k++) begin
      step();
      check("decim_hold_sign", if_sign, 1);
    end
    step();
    check("decim_new_sign", if_sign, 0);
    step(); check("decim_pre_switch", if_valid, 0);
    step(); check("decim_pre_switch", if_valid, 0);
    cfg_decim = 4'd1;
    for (int k = 19; k <= 24; k++) begin
      step();
      check("decim_switch_valid", if_valid, (k % 2) == 1);
    end

    // monitor: all ones, then zeros, then alternating, then disabled
    cfg_decim = 4'd0; fe_sign = 1'b0; fe_mag = 1'b1; cfg_win = 24'd10;
    rst = 1'b1; step(); rst = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      step();
      check("mon_ready_spacing", mag_ready, (k % 10 == 1) && (k > 1));
      if (k == 11) check("mon_first_window", mag_count, 8);
      if (k == 21) check("mon_all_ones", mag_count, 10);
    end
    fe_mag = 1'b0;
    for (int k = 31; k <= 55; k++) step();
    check("mon_all_zeros", mag_count, 0);
    for (int k = 56; k <= 85; k++) begin
      fe_mag = ~fe_mag;
      step();
    end
    check("mon_alternating", mag_count, 5);
    cfg_win = '0;
    for (int k = 0; k < 30; k++) begin
      fe_mag = k[0];
      step();
      check("mon_off_ready", mag_ready, 0);
      check("mon_off_count", mag_count, 5);
    end

    // reset mid-window
    cfg_win = 24'd10; fe_mag = 1'b1; fe_sign = 1'b1;
    for (int k = 0; k < 6; k++) step();
    rst = 1'b1; step(); rst = 1'b0;
    check("rst_if_sign", if_sign, 0);
    check("rst_if_mag", if_mag, 0);
    check("rst_if_valid", if_valid, 0);
    check("rst_mag_ready", mag_ready, 0);
    check("rst_mag_count", mag_count, 0);
    cfg_test_en = 1'b1;
    found = 0; cnt_at = -1;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == 1) begin
        check("rst_seed_sign", if_sign, 1);
        check("rst_seed_mag", if_mag, 1);
      end
      if (mag_ready && found == 0) begin
        found = k; cnt_at = int'(mag_count);
      end
    end
    check("rst_next_ready_at", found, 11);
    check("rst_next_count", cnt_at, 6);

    // randomized traffic with quasi-static configuration
    for (int k = 0; k < 4000; k++) begin
      if (k % 50 == 0) begin
        cfg_decim    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
        cfg_win      = WIN_W'($urandom_range(0, 12));
        cfg_sign_inv = 1'($urandom_range(0, 1));
        cfg_test_en  = 1'($urandom_range(0, 1));
      end
      rst     = ($urandom_range(0, 299) == 0);
      fe_sign = 1'($urandom_range(0, 1));
      fe_mag  = 1'($urandom_range(0, 1));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fe_sample_conditioner.md
# fe_sample_conditioner

- Front-end conditioning stage that sits directly upstream of the GPS baseband tracking channels.
- Synchronises the raw `sign`/`mag` bits from the RF front end into the `clk` domain, optionally inverts sign, and decimates to a programmable rate.
- Can substitute a PRBS7 test pattern for the front-end bits.
- Drives `if_sign`/`if_mag` plus a sample strobe into the baseband.
- Runs a windowed magnitude-bit counter that firmware reads for AGC/level monitoring.

## Interface
Parameters:
- SYNC_STAGES, 2, flops in the front-end input synchroniser (≥2)
- WIN_W, 24, width of window length and magnitude count

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- fe_sign  in  1  raw sign bit from RF front end, asynchronous to clk
- fe_mag  in  1  raw magnitude bit from RF front end, asynchronous to clk
- cfg_decim  in  4  decimation: one output sample every cfg_decim+1 clocks
- cfg_sign_inv  in  1  invert output sign
- cfg_test_en  in  1  replace front-end bits with PRBS7 pattern
- cfg_win  in  WIN_W  monitor window length in output samples; 0 = monitor disabled
- if_sign  out  1  conditioned sign to baseband
- if_mag  out  1  conditioned magnitude to baseband
- if_valid  out  1  one-cycle strobe, new if_sign/if_mag presented
- mag_count  out  WIN_W  number of if_mag=1 samples in last completed window
- mag_ready  out  1  one-cycle pulse, mag_count updated

## Operation
- **Synchroniser:** each of fe_sign and fe_mag passes through a SYNC_STAGES flop chain. There is no logic between the chain stages.
- **Decimator:**
  - 4-bit counter dcnt increments every clock.
  - When dcnt ≥ cfg_decim: strobe, and dcnt ← 0.
  - With cfg_decim=0 the strobe fires every clock.
  - Lowering cfg_decim below the current dcnt fires the strobe on the next clock. There is no lost or double strobe beyond that.
- **Source mux:** selected sign/mag = cfg_test_en ? {lfsr[6], lfsr[5]} : synchronised {sign, mag}.
- **PRBS7:**
  - Polynomial x^7+x^6+1; seed 7'h7F.
  - Advances only on strobe cycles: lfsr ← {lfsr[5:0], lfsr[6]^lfsr[5]}.
  - The output register samples the pre-advance value.
  - The LFSR free-runs regardless of cfg_test_en; toggling test mode never reseeds it.
- **Output register:** on a strobe, if_sign ← sel_sign ^ cfg_sign_inv and if_mag ← sel_mag. if_valid is registered alongside and is high for exactly that cycle.
- **Magnitude monitor:**
  - Operates on the registered if_valid/if_mag.
  - Keeps scnt (samples in window) and acc (ones in window), both WIN_W bits.
  - On if_valid:
    - If scnt ≥ cfg_win−1: mag_count ← acc+if_mag, mag_ready ← 1, scnt ← 0, acc ← 0.
    - Otherwise: scnt++, acc += if_mag.
  - acc ≤ cfg_win ≤ 2^WIN_W−1, so no saturation logic is needed.
  - cfg_win=0: scnt and acc are held at 0, mag_ready stays 0, and mag_count holds its last value.
  - Shrinking cfg_win mid-window closes the window on the next if_valid.
- **Reset values** (in the cycle after rst is sampled high, and for as long as it is held):
  - if_sign, if_mag, if_valid, mag_ready: 0.
  - mag_count: 0.
  - dcnt, scnt, acc: 0.
  - lfsr: 7'h7F.
  - Synchroniser flops: 0.
- **Reset mid-window:** the partial window is discarded; the first mag_ready comes after a full cfg_win samples.

## Timing
- **Pin to output:** fe_* to if_sign/if_mag is SYNC_STAGES+1 clocks (3 at default) with cfg_decim=0. With decimation, add up to cfg_decim clocks.
- **Monitor latency:** mag_ready and the new mag_count appear one clock after the if_valid that closes the window. mag_count is stable until the next mag_ready.
- **Strobe spacing:** if_valid never asserts on consecutive clocks unless cfg_decim=0.
- **Config timing:** config inputs are quasi-static and are sampled every clock with no shadowing.
- **Between strobes:** if_sign/if_mag hold their value.

## Structure
- **Shared package `gps_fe_pkg`:**
  - PRBS7 seed (7'h7F) and tap positions.
  - Default WIN_W.
  - Decimator width (4).
- **Sub-module `fe_mag_monitor`:** contains the window counter, accumulator, mag_count and mag_ready. Its inputs are if_valid, if_mag and cfg_win.
- **Inline in the top:** the synchroniser, decimator, LFSR and output register.

## Test plan
- **Pass-through:** cfg_decim=0, test off, fe_sign=1, fe_mag=0 held after reset -> if_sign=1, if_mag=0 from clock 3 onward; if_valid high every clock.
- **Decimation:** cfg_decim=3 -> if_valid once per 4 clocks; toggling fe_sign between strobes is not reflected until the next strobe; switching to cfg_decim=1 when dcnt=3 -> strobe on the next clock, then every 2 clocks.
- **PRBS:** cfg_test_en=1, cfg_decim=0 after reset -> if_sign sequence 1,1,1,1,1,1,1,0,… and if_mag 1,1,1,1,1,1,0,…; period 127 strobes; with cfg_sign_inv=1 the sign sequence is inverted.
- **Monitor counts:**
  - cfg_win=10, fe_mag tied 1 -> mag_ready every 10 strobes, one clock after the 10th if_valid, mag_count=10.
  - fe_mag tied 0 -> mag_count=0.
  - Alternating fe_mag at cfg_decim=0 -> mag_count=5.
- **Monitor disabled:** cfg_win=0 -> mag_ready never asserts; mag_count unchanged.
- **Reset mid-window:** rst asserted for 1 clock after 6 samples of a cfg_win=10 window -> all outputs 0 and lfsr=7'h7F; next mag_ready occurs after 10 further strobes.
